// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG TDR controlling a functional/IJTAG data mux select. The select only
// moves after a park handshake with the functional owner plus a settle delay.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] capture_data_in,
    input  logic             park_ack,
    output logic             park_req,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             timeout_err
);

    localparam int TDR_W = WIDTH + 2;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 32'sd1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 32'sd1);

    typedef enum logic [2:0] {
        ST_FUNC       = 3'd0,
        ST_PARK       = 3'd1,
        ST_SETTLE_IN  = 3'd2,
        ST_IJTAG      = 3'd3,
        ST_SETTLE_OUT = 3'd4,
        ST_FAULT      = 3'd5
    } state_t;

    logic [TDR_W-1:0] shift_r;
    logic             shadow_en_r;
    logic [WIDTH-1:0] shadow_data_r;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             timeout_r;
    logic             timeout_set_s;
    logic             clear_err_s;
    logic             capture_s;
    logic             shift_en_s;
    logic             update_s;
    logic             park_req_r;
    logic             select_r;

    // The owner is asked to stay parked in every state that is on its way to,
    // inside, or leaving the IJTAG path.
    function automatic logic park_req_of(input state_t st);
        case (st)
            ST_PARK, ST_SETTLE_IN, ST_IJTAG, ST_SETTLE_OUT: park_req_of = 1'b1;
            default:                                        park_req_of = 1'b0;
        endcase
    endfunction

    function automatic logic select_of(input state_t st);
        case (st)
            ST_IJTAG: select_of = 1'b1;
            default:  select_of = 1'b0;
        endcase
    endfunction

    // TDR access strobes; all gated by the TDR select.
    always_comb begin
        capture_s   = ijtag_sel & ijtag_ce;
        shift_en_s  = ijtag_sel & ijtag_se & ~ijtag_ce;
        update_s    = ijtag_sel & ijtag_ue;
        clear_err_s = update_s & shift_r[1];
    end

    // Shift register: capture has priority over shift.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            shift_r <= {TDR_W{1'b0}};
        end else if (capture_s) begin
            shift_r <= {capture_data_in, timeout_r, select_r};
        end else if (shift_en_s) begin
            shift_r <= {ijtag_si, shift_r[TDR_W-1:1]};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Shadow register; the clear_err bit is consumed as a pulse, not stored.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            shadow_en_r   <= 1'b0;
            shadow_data_r <= {WIDTH{1'b0}};
        end else if (update_s) begin
            shadow_en_r   <= shift_r[0];
            shadow_data_r <= shift_r[TDR_W-1:2];
        end else begin
            shadow_en_r   <= shadow_en_r;
            shadow_data_r <= shadow_data_r;
        end
    end

    // Next-state and counter logic for the park/settle sequencer.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        timeout_set_s = 1'b0;
        case (state_r)
            ST_FUNC: begin
                if (shadow_en_r) begin
                    state_s = ST_PARK;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_FUNC;
                end
            end
            ST_PARK: begin
                if (!shadow_en_r) begin
                    state_s = ST_FUNC;
                    cnt_s   = CNT_ZERO;
                end else if (park_ack) begin
                    state_s = ST_SETTLE_IN;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == ACK_LAST) begin
                    state_s       = ST_FAULT;
                    cnt_s         = CNT_ZERO;
                    timeout_set_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SETTLE_IN: begin
                if (!shadow_en_r) begin
                    state_s = ST_SETTLE_OUT;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_IJTAG;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_IJTAG: begin
                if (!shadow_en_r) begin
                    state_s = ST_SETTLE_OUT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_IJTAG;
                end
            end
            ST_SETTLE_OUT: begin
                // Re-enable is deliberately ignored until FUNC is reached.
                if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_FUNC;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_FAULT: begin
                if (!shadow_en_r) begin
                    state_s = ST_FUNC;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                state_s = ST_FUNC;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Sequencer state, counter and output registers decoded from next state.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            state_r    <= ST_FUNC;
            cnt_r      <= CNT_ZERO;
            park_req_r <= 1'b0;
            select_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            park_req_r <= park_req_of(state_s);
            select_r   <= select_of(state_s);
        end
    end

    // Sticky timeout flag; a simultaneous set beats the clear pulse.
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            timeout_r <= 1'b0;
        end else if (timeout_set_s) begin
            timeout_r <= 1'b1;
        end else if (clear_err_s) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign ijtag_so       = shift_r[0];
    assign park_req       = park_req_r;
    assign ijtag_select   = select_r;
    assign ijtag_data_out = shadow_data_r;
    assign timeout_err    = timeout_r;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Bench for the IJTAG data-mux controller: directed scenarios plus randomized
// shift and park-ack timing checked against a timing-formula/queue model.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

    localparam int W = 3;
    localparam int S = 4;
    localparam int T = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel, ce, se, ue, si;
    logic         so;
    logic [W-1:0] cap;
    logic         ack;
    logic         preq;
    logic         select;
    logic [W-1:0] dout;
    logic         terr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    firebird7_in_gate1_tessent_data_mux_ctrl dut (
        .ijtag_tck       (clk),
        .ijtag_reset     (rst_n),
        .ijtag_sel       (sel),
        .ijtag_ce        (ce),
        .ijtag_se        (se),
        .ijtag_ue        (ue),
        .ijtag_si        (si),
        .ijtag_so        (so),
        .capture_data_in (cap),
        .park_ack        (ack),
        .park_req        (preq),
        .ijtag_select    (select),
        .ijtag_data_out  (dout),
        .timeout_err     (terr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic shift_word(input logic [4:0] w);
        for (int i = 0; i < 5; i++) begin
            sel = 1'b1;
            se  = 1'b1;
            si  = w[i];
            tick();
        end
        se = 1'b0;
        si = 1'b0;
    endtask

    task automatic do_update();
        sel = 1'b1;
        ue  = 1'b1;
        tick();
        ue  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (so !== 1'b0) begin bad++; $display("FAIL reset_so got=%0b exp=0", so); end
        total++; if (preq !== 1'b0) begin bad++; $display("FAIL reset_park_req got=%0b exp=0", preq); end
        total++; if (select !== 1'b0) begin bad++; $display("FAIL reset_select got=%0b exp=0", select); end
        total++; if (dout !== 3'b000) begin bad++; $display("FAIL reset_data_out got=%0b exp=000", dout); end
        total++; if (terr !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b exp=0", terr); end
    endtask

    task automatic test_enable();
        ack = 1'b1;
        shift_word(5'b10101);
        do_update();
        total++; if (preq !== 1'b0) begin bad++; $display("FAIL en_preq_N got=%0b exp=0", preq); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                total++; if (dout !== 3'b101) begin bad++; $display("FAIL en_data_out got=%0b exp=101", dout); end
            end
            total++; if (preq !== 1'b1) begin bad++; $display("FAIL en_preq k=%0d got=%0b exp=1", k, preq); end
            total++; if (select !== (k >= 6)) begin bad++; $display("FAIL en_select k=%0d got=%0b exp=%0b", k, select, (k >= 6)); end
        end
    endtask

    task automatic test_release();
        shift_word(5'b10100);
        do_update();
        total++; if (select !== 1'b1) begin bad++; $display("FAIL rel_select_M got=%0b exp=1", select); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++; if (select !== 1'b0) begin bad++; $display("FAIL rel_select k=%0d got=%0b exp=0", k, select); end
            total++; if (preq !== (k <= 4)) begin bad++; $display("FAIL rel_preq k=%0d got=%0b exp=%0b", k, preq, (k <= 4)); end
        end
    endtask

    task automatic test_timeout();
        ack = 1'b0;
        shift_word(5'b00001);
        do_update();
        for (int k = 1; k <= T + 1; k++) begin
            tick();
            total++; if (preq !== (k <= T)) begin bad++; $display("FAIL to_preq k=%0d got=%0b exp=%0b", k, preq, (k <= T)); end
            total++; if (terr !== (k > T)) begin bad++; $display("FAIL to_flag k=%0d got=%0b exp=%0b", k, terr, (k > T)); end
        end
        cap = 3'b000;
        ce  = 1'b1;
        tick();
        ce  = 1'b0;
        total++; if (so !== 1'b0) begin bad++; $display("FAIL to_cap_bit0 got=%0b exp=0", so); end
        se = 1'b1;
        tick();
        se = 1'b0;
        total++; if (so !== 1'b1) begin bad++; $display("FAIL to_cap_bit1 got=%0b exp=1", so); end
        total++; if (terr !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0b exp=1", terr); end
        shift_word(5'b00010);
        do_update();
        total++; if (terr !== 1'b0) begin bad++; $display("FAIL to_clear got=%0b exp=0", terr); end
        tick();
        total++; if (preq !== 1'b0) begin bad++; $display("FAIL to_func_preq got=%0b exp=0", preq); end
    endtask

    task automatic test_capture();
        logic [4:0] exp_tdr;
        ack = 1'b1;
        shift_word(5'b00001);
        do_update();
        for (int k = 0; k < S + 2; k++) tick();
        total++; if (select !== 1'b1) begin bad++; $display("FAIL cap_in_ijtag got=%0b exp=1", select); end
        cap = 3'b110;
        ce  = 1'b1;
        tick();
        ce  = 1'b0;
        exp_tdr = {3'b110, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            total++; if (so !== exp_tdr[i]) begin bad++; $display("FAIL cap_so bit=%0d got=%0b exp=%0b", i, so, exp_tdr[i]); end
            se = 1'b1;
            si = 1'b0;
            tick();
            se = 1'b0;
        end
    endtask

    task automatic test_priority();
        logic [4:0] exp_tdr;
        cap = 3'b011;
        sel = 1'b1;
        ce  = 1'b1;
        se  = 1'b1;
        si  = 1'b1;
        tick();
        ce  = 1'b0;
        se  = 1'b0;
        exp_tdr = {3'b011, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            total++; if (so !== exp_tdr[i]) begin bad++; $display("FAIL prio_so bit=%0d got=%0b exp=%0b", i, so, exp_tdr[i]); end
            se = 1'b1;
            si = 1'b0;
            tick();
            se = 1'b0;
        end
        shift_word(5'b11100);
        sel = 1'b0;
        ue  = 1'b1;
        se  = 1'b1;
        si  = 1'b1;
        tick();
        tick();
        ue  = 1'b0;
        se  = 1'b0;
        si  = 1'b0;
        sel = 1'b1;
        total++; if (dout !== 3'b000) begin bad++; $display("FAIL nosel_data_out got=%0b exp=000", dout); end
        total++; if (select !== 1'b1) begin bad++; $display("FAIL nosel_select got=%0b exp=1", select); end
        total++; if (so !== 1'b0) begin bad++; $display("FAIL nosel_shift got=%0b exp=0", so); end
    endtask

    task automatic test_reset_in_ijtag();
        shift_word(5'b11101);
        do_update();
        tick();
        total++; if (dout !== 3'b111) begin bad++; $display("FAIL rij_data_out got=%0b exp=111", dout); end
        total++; if (select !== 1'b1) begin bad++; $display("FAIL rij_select got=%0b exp=1", select); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if ({so, preq, select, dout, terr} !== 7'b0) begin
            bad++; $display("FAIL rij_outputs got=%0b exp=0", {so, preq, select, dout, terr});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if ({preq, select} !== 2'b00) begin bad++; $display("FAIL rij_no_settle k=%0d got=%0b exp=00", k, {preq, select}); end
        end
    endtask

    task automatic test_random_shift();
        logic q[$];
        logic b;
        logic s;
        apply_reset();
        q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int n = 0; n < 60; n++) begin
            b = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0);
            sel = s;
            se  = 1'b1;
            si  = b;
            total++; if (so !== q[0]) begin bad++; $display("FAIL rshift n=%0d got=%0b exp=%0b", n, so, q[0]); end
            tick();
            if (s) begin
                void'(q.pop_front());
                q.push_back(b);
            end
        end
        sel = 1'b1;
        se  = 1'b0;
        si  = 1'b0;
    endtask

    task automatic test_random_ack();
        int ks[5];
        int k;
        int tmax;
        logic ok;
        logic [W-1:0] d;
        ks[0] = 1;
        ks[1] = T;
        ks[2] = T + 1;
        ks[3] = int'($urandom_range(2, T - 1));
        ks[4] = int'($urandom_range(T + 2, T + 16));
        for (int it = 0; it < 5; it++) begin
            k  = ks[it];
            ok = (k <= T);
            tmax = ok ? (k + S + 3) : (T + 4);
            apply_reset();
            ack = 1'b0;
            d   = W'($urandom_range(0, 7));
            shift_word({d, 2'b01});
            do_update();
            for (int t = 1; t <= tmax; t++) begin
                tick();
                if (t == 1) begin
                    total++; if (dout !== d) begin bad++; $display("FAIL rack_data k=%0d got=%0b exp=%0b", k, dout, d); end
                end
                total++; if (preq !== (ok ? 1'b1 : (t <= T))) begin
                    bad++; $display("FAIL rack_preq k=%0d t=%0d got=%0b exp=%0b", k, t, preq, (ok ? 1'b1 : (t <= T)));
                end
                total++; if (select !== (ok && (t >= 1 + k + S))) begin
                    bad++; $display("FAIL rack_select k=%0d t=%0d got=%0b exp=%0b", k, t, select, (ok && (t >= 1 + k + S)));
                end
                total++; if (terr !== (!ok && (t > T))) begin
                    bad++; $display("FAIL rack_timeout k=%0d t=%0d got=%0b exp=%0b", k, t, terr, (!ok && (t > T)));
                end
                if (t < k) ack = 1'b0;
                else if (t == k) ack = 1'b1;
                else ack = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 1'b1; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
        cap = 3'b000;
        ack = 1'b0;
        test_reset();
        test_enable();
        test_release();
        test_timeout();
        test_capture();
        test_priority();
        test_reset_in_ijtag();
        test_random_shift();
        test_random_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_ctrl.md
Name: firebird7_in_gate1_tessent_data_mux_ctrl

Overview:
- IJTAG-side controller for a WIDTH-bit functional/IJTAG data mux.
- Sits on the gate1 IJTAG network as a TDR: shift, capture, update.
- Drives the mux's `ijtag_select` and `ijtag_data_in`.
- Changes `ijtag_select` only after a park handshake with the functional owner plus a settle delay, so functional logic never sees an unannounced switch.

Parameters:
- WIDTH, 3: mux data width.
- SETTLE_CYCLES, 4: cycles held between park grant and select change, in both directions; legal range 1 to 255.
- ACK_TIMEOUT, 64: cycles to wait for `park_ack` before fault; legal range 1 to 65535.

Ports:
- ijtag_tck  in  1  clock; all state changes on rising edge.
- ijtag_reset  in  1  reset; synchronous, active-low.
- ijtag_sel  in  1  TDR selected.
- ijtag_ce  in  1  capture enable.
- ijtag_se  in  1  shift enable.
- ijtag_ue  in  1  update enable.
- ijtag_si  in  1  scan in.
- ijtag_so  out  1  scan out, equal to `shift_reg[0]`.
- capture_data_in  in  WIDTH  functional-side mux output, observed on capture.
- park_ack  in  1  functional owner confirms it is parked.
- park_req  out  1  request functional owner to park.
- ijtag_select  out  1  mux select; 1 means the IJTAG path is selected.
- ijtag_data_out  out  WIDTH  drives the mux `ijtag_data_in`.
- timeout_err  out  1  sticky park-timeout flag.

Behaviour:
- TDR: `shift_reg` is WIDTH+2 bits. Bit0 = enable. Bit1 = clear_err on write, timeout_err on read. Bits [WIDTH+1:2] = data.
- Capture (`sel & ce`): `shift_reg <= {capture_data_in, timeout_err, ijtag_select}`.
- Shift (`sel & se & !ce`): `shift_reg <= {ijtag_si, shift_reg[WIDTH+1:1]}`. Capture wins over shift when both are asserted.
- Update (`sel & ue`): `shadow <= shift_reg`.
  - `ijtag_data_out = shadow data`, registered, effective the cycle after update, regardless of FSM state.
  - `shadow_en = shadow[0]`.
  - clear_err is a one-cycle pulse on update when `shift_reg[1] = 1`. If a timeout sets the flag in the same cycle, set wins.
- FSM is Moore; all outputs decode from registered state.
  - FUNC: `park_req = 0`, `select = 0`. If `shadow_en`, go to PARK with `cnt = 0`.
  - PARK: `park_req = 1`, `select = 0`.
    - If `!shadow_en`, go to FUNC (request withdrawn).
    - Else if `park_ack`, go to SETTLE_IN with `cnt = 0`.
    - Else if `cnt == ACK_TIMEOUT-1`, set `timeout_err` and go to FAULT.
    - Else `cnt++`.
  - SETTLE_IN: `park_req = 1`, `select = 0`. After SETTLE_CYCLES cycles in state, go to IJTAG. `shadow_en` dropping here goes to SETTLE_OUT.
  - IJTAG: `park_req = 1`, `select = 1`. If `!shadow_en`, go to SETTLE_OUT with `cnt = 0`.
  - SETTLE_OUT: `park_req = 1`, `select = 0`. After SETTLE_CYCLES cycles, go to FUNC. `park_req` falls on entry to FUNC. Re-enable during SETTLE_OUT is ignored until FUNC.
  - FAULT: `park_req = 0`, `select = 0`. If `!shadow_en`, go to FUNC. A new enable=1 update is required to retry.
- `park_ack` is ignored outside PARK. Loss of ack in IJTAG does not alter state.
- Latency with ack already high, update edge at cycle N:
  - `park_req` high at N+1.
  - SETTLE_IN entered at N+2.
  - `ijtag_select` high at N+2+SETTLE_CYCLES.
- Reset (`ijtag_reset = 0` at a clock edge), applied in any state including mid-shift or IJTAG:
  - `shift_reg`, `shadow`, `cnt` and `timeout_err` clear to 0; state goes to FUNC.
  - Outputs become `ijtag_so = 0`, `park_req = 0`, `ijtag_select = 0`, `ijtag_data_out = 0`.
  - No settle sequence is applied.
- With `ijtag_sel = 0`, `ce`, `se` and `ue` have no effect.

Test Plan:
- Reset, then shift in 5'b101_0_1 and update; tie `park_ack = 1` -> `ijtag_data_out = 3'b101` the next cycle; `park_req` high at N+1; `ijtag_select` high at N+6 (SETTLE_CYCLES = 4).
- From IJTAG, update with enable = 0 -> `ijtag_select` low the next state cycle; `park_req` stays high 4 more cycles, then low; FSM is in FUNC.
- Hold `park_ack = 0` after enable -> `park_req` high for 64 cycles, then `timeout_err = 1` and `park_req = 0`. Capture shows bit1 = 1. Update with enable = 0, clear_err = 1 -> flag clears and FSM returns to FUNC.
- Capture with `capture_data_in = 3'b110` while in IJTAG, then shift 5 bits -> `so` sequence 1, 0, 0, 1, 1 (LSB first).
- Assert `ce` and `se` together with `sel = 1` -> capture occurs, no shift. Deassert `sel` and pulse `ue` -> `shadow` unchanged.
- Assert reset while in IJTAG with `ijtag_data_out = 3'b111` -> next cycle all outputs are 0 and FSM is in FUNC; no settle sequence.
